ibex_pmp_csr_regs: RTL and testbench

IBEX_PMP_CSR_REGS -- requirements
Module: ibex_pmp_csr_regs

---
 rtl/ibex_pkg.sv | 51 +++++
 rtl/ibex_pmp_cfg_legalize.sv | 46 ++++
 rtl/ibex_pmp_csr_regs.sv | 146 ++++++++++++++
 tb/tb_ibex_pmp_csr_regs.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types and CSR addresses used by the PMP configuration registers.
// Only the subset needed by the PMP CSR slice is defined here.
package ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
    localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
    localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
    localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
    localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
    localparam logic [11:0] CSR_MSECCFG   = 12'h747;
    localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

    // Mask with the n lowest bits set; n <= 0 gives an all-zero mask.
    function automatic logic [31:0] pmp_low_mask(input int n);
        logic [31:0] m;
        for (int b = 0; b < 32; b++) begin
            m[b] = (b < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/ibex_pmp_cfg_legalize.sv
// WARL legalization of one pmpcfg byte write: returns the value the entry
// takes when this byte is written (the old value when the write is refused).
module ibex_pmp_cfg_legalize
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0
) (
    input  pmp_cfg_t    cfg_i,
    input  logic [7:0]  wdata_i,
    input  logic        locked_i,
    input  logic        mml_i,
    input  logic        rlb_i,
    output pmp_cfg_t    cfg_o
);

    pmp_cfg_t wr_cfg;
    logic     shared_enc;
    logic     unused_wdata;

    assign unused_wdata = ^wdata_i[6:5];

    always_comb begin
        wr_cfg.lock  = wdata_i[7];
        wr_cfg.mode  = pmp_cfg_mode_e'(wdata_i[4:3]);
        wr_cfg.exec  = wdata_i[2];
        wr_cfg.write = wdata_i[1];
        wr_cfg.read  = wdata_i[0];
        // NA4 is not representable once the granule exceeds four bytes
        if ((PMPGranularity > 0) && (wr_cfg.mode == PMP_MODE_NA4)) begin
            wr_cfg.mode = cfg_i.mode;
        end

        shared_enc = ~wdata_i[0] & wdata_i[1];

        cfg_o = wr_cfg;
        if (locked_i) begin
            cfg_o = cfg_i;
        end else if (!mml_i && shared_enc) begin
            cfg_o = cfg_i;
        end else if (mml_i && !rlb_i && wdata_i[7] && wdata_i[2] && !shared_enc) begin
            // machine mode may not gain new executable locked regions
            cfg_o = cfg_i;
        end
    end

endmodule

// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR register file: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh with
// WARL rules, one-cycle registered response and direct outputs to the checker.
module ibex_pmp_csr_regs
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          csr_req_i,
    input  logic          csr_we_i,
    input  logic [11:0]   csr_addr_i,
    input  logic [31:0]   csr_wdata_i,
    input  priv_lvl_e     priv_lvl_i,
    output logic          csr_rvalid_o,
    output logic [31:0]   csr_rdata_o,
    output logic          csr_err_o,
    output pmp_cfg_t      csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]   csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t  csr_pmp_mseccfg_o
);

    localparam logic [31:0] NapotOnes = pmp_low_mask(int'(PMPGranularity) - 1);
    localparam logic [31:0] GranClear = pmp_low_mask(int'(PMPGranularity));

    pmp_cfg_t           cfg_q     [PMPNumRegions];
    pmp_cfg_t           cfg_legal [PMPNumRegions];
    logic [33:0]        addr_q    [PMPNumRegions];
    pmp_mseccfg_t       msec_q, msec_d;
    logic [PMPNumRegions-1:0] locked, addr_locked, cfg_we, addr_we;

    logic        is_cfg, is_addr, is_msec, is_msech;
    logic        acc_err, wr_en, msec_we, any_lock;
    logic [1:0]  cfg_word;
    logic [3:0]  addr_idx;
    logic [31:0] rdata;

    always_comb begin
        is_cfg   = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
        is_addr  = (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
        is_msec  = (csr_addr_i == CSR_MSECCFG);
        is_msech = (csr_addr_i == CSR_MSECCFGH);
        cfg_word = csr_addr_i[1:0];
        addr_idx = csr_addr_i[3:0];
        acc_err  = ~(is_cfg | is_addr | is_msec | is_msech) | (priv_lvl_i != PRIV_LVL_M);
        wr_en    = csr_req_i & csr_we_i & ~acc_err;
        msec_we  = wr_en & is_msec;
    end

    for (genvar i = 0; i < int'(PMPNumRegions); i++) begin : g_entry
        assign locked[i] = cfg_q[i].lock & ~msec_q.rlb;

        // A TOR region above uses this address as its base
        if (i < int'(PMPNumRegions) - 1) begin : g_tor
            assign addr_locked[i] = locked[i] |
                                    (locked[i+1] & (cfg_q[i+1].mode == PMP_MODE_TOR));
        end else begin : g_last
            assign addr_locked[i] = locked[i];
        end

        assign cfg_we[i]  = wr_en & is_cfg & (cfg_word == 2'(i / 4));
        assign addr_we[i] = wr_en & is_addr & ~addr_locked[i] & (addr_idx == 4'(i));

        ibex_pmp_cfg_legalize #(
            .PMPGranularity (PMPGranularity)
        ) u_legalize (
            .cfg_i    (cfg_q[i]),
            .wdata_i  (csr_wdata_i[8*(i%4) +: 8]),
            .locked_i (locked[i]),
            .mml_i    (msec_q.mml),
            .rlb_i    (msec_q.rlb),
            .cfg_o    (cfg_legal[i])
        );

        assign csr_pmp_cfg_o[i]  = cfg_q[i];
        assign csr_pmp_addr_o[i] = addr_q[i];
    end

    assign csr_pmp_mseccfg_o = msec_q;

    always_comb begin
        any_lock = 1'b0;
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            any_lock = any_lock | cfg_q[i].lock;
        end
        msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
        msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
        msec_d.rlb  = csr_wdata_i[2] & (msec_q.rlb | ~any_lock);
    end

    always_comb begin
        rdata = 32'h0;
        for (int i = 0; i < int'(PMPNumRegions); i++) begin
            if (is_cfg && ((i / 4) == int'(cfg_word))) begin
                rdata[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                       cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
            end
            if (is_addr && (addr_idx == 4'(i))) begin
                rdata = addr_q[i][33:2];
                if (cfg_q[i].mode == PMP_MODE_NAPOT) begin
                    rdata = rdata | NapotOnes;
                end else if (cfg_q[i].mode != PMP_MODE_NA4) begin
                    rdata = rdata & ~GranClear;
                end
            end
        end
        if (is_msec) begin
            rdata = {29'h0, msec_q.rlb, msec_q.mmwp, msec_q.mml};
        end
        if (acc_err) begin
            rdata = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            msec_q       <= '0;
            csr_rvalid_o <= 1'b0;
            csr_rdata_o  <= 32'h0;
            csr_err_o    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(PMPNumRegions); i++) begin
                if (cfg_we[i]) begin
                    cfg_q[i] <= cfg_legal[i];
                end
                if (addr_we[i]) begin
                    addr_q[i] <= {csr_wdata_i, 2'b00};
                end
            end
            if (msec_we) begin
                msec_q <= msec_d;
            end
            csr_rvalid_o <= csr_req_i;
            csr_err_o    <= csr_req_i & acc_err;
            if (csr_req_i) begin
                csr_rdata_o <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Directed bench for ibex_pmp_csr_regs (granularity 2, four regions):
// a stateful vector table plus hand sequences for back-to-back, reset and rlb.
module tb_ibex_pmp_csr_regs;
    import ibex_pkg::*;

    localparam int G = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         csr_req, csr_we;
    logic [11:0]  csr_addr;
    logic [31:0]  csr_wdata;
    priv_lvl_e    priv;
    logic         rvalid, err;
    logic [31:0]  rdata;
    pmp_cfg_t     cfg_o  [N];
    logic [33:0]  addr_o [N];
    pmp_mseccfg_t msec_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        priv_lvl_e   priv;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ibex_pmp_csr_regs #(
        .PMPGranularity (G),
        .PMPNumRegions  (N)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .csr_req_i         (csr_req),
        .csr_we_i          (csr_we),
        .csr_addr_i        (csr_addr),
        .csr_wdata_i       (csr_wdata),
        .priv_lvl_i        (priv),
        .csr_rvalid_o      (rvalid),
        .csr_rdata_o       (rdata),
        .csr_err_o         (err),
        .csr_pmp_cfg_o     (cfg_o),
        .csr_pmp_addr_o    (addr_o),
        .csr_pmp_mseccfg_o (msec_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                       input priv_lvl_e p, input logic e_err, input logic chk,
                       input logic [31:0] e_rd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.priv = p;
        v.exp_err = e_err; v.chk_data = chk; v.exp_rdata = e_rd;
        vecs.push_back(v);
    endtask

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input priv_lvl_e p, input logic e_err, input logic chk,
                          input logic [31:0] e_rd, input string tag);
        @(negedge clk);
        csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wdata; priv = p;
        @(posedge clk);
        #1;
        csr_req = 1'b0; csr_we = 1'b0;
        check({tag, " rvalid"}, 64'(rvalid), 64'(1));
        check({tag, " err"}, 64'(err), 64'(e_err));
        if (chk) check({tag, " rdata"}, 64'(rdata), 64'(e_rd));
    endtask

    initial begin
        rst = 1'b1; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        priv = PRIV_LVL_M;
        repeat (2) @(posedge clk);
        #1;
        check("reset rvalid", 64'(rvalid), 64'(0));
        check("reset rdata", 64'(rdata), 64'(0));
        check("reset err", 64'(err), 64'(0));
        check("reset cfg0", 64'(cfg_o[0]), 64'(0));
        check("reset addr3", 64'(addr_o[3]), 64'(0));
        check("reset mseccfg", 64'(msec_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        //   we  addr     wdata         priv        err chk rdata
        add(1, 12'h3A0, 32'h00001F0F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h00001F0F);
        add(0, 12'h3A3, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(1, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(0, 12'h3B1, 32'h0,        PRIV_LVL_M, 0, 1, 32'h1);
        add(1, 12'h3A0, 32'h00001F1F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h1);
        add(1, 12'h3B0, 32'h00001237, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h00001237);
        add(1, 12'h3A0, 32'h00001F0F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h00001234);
        add(1, 12'h3A0, 32'h00000002, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000000F);
        add(1, 12'h3A0, 32'h00000013, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000000B);
        add(1, 12'h3A0, 32'h000000FF, PRIV_LVL_U, 1, 1, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000000B);
        add(0, 12'h300, 32'h0,        PRIV_LVL_M, 1, 1, 32'h0);
        add(1, 12'h757, 32'hFFFFFFFF, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h757, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(1, 12'h3B4, 32'hFFFFFFFF, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B4, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(1, 12'h3A0, 32'h0000880B, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000880B);
        add(1, 12'h3B0, 32'h00000777, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h00001234);
        add(1, 12'h3B1, 32'h00000055, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3B1, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(1, 12'h3A0, 32'h00001F0F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000880F);
        add(1, 12'h747, 32'h00000004, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h747, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0);
        add(1, 12'h747, 32'h00000003, PRIV_LVL_M, 0, 0, 32'h0);
        add(1, 12'h747, 32'h00000000, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h747, 32'h0,        PRIV_LVL_M, 0, 1, 32'h3);
        add(1, 12'h747, 32'h00000004, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h747, 32'h0,        PRIV_LVL_M, 0, 1, 32'h3);
        add(1, 12'h3A0, 32'h0085880F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0000880F);
        add(1, 12'h3A0, 32'h0086880F, PRIV_LVL_M, 0, 0, 32'h0);
        add(0, 12'h3A0, 32'h0,        PRIV_LVL_M, 0, 1, 32'h0086880F);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].priv,
                   vecs[i].exp_err, vecs[i].chk_data, vecs[i].exp_rdata,
                   $sformatf("vec%0d", i));
        end

        check("out cfg0", 64'(cfg_o[0]), 64'h0F);
        check("out cfg1", 64'(cfg_o[1]), 64'h28);
        check("out cfg2", 64'(cfg_o[2]), 64'h26);
        check("out addr0", 64'(addr_o[0]), 64'h48DC);
        check("out mseccfg", 64'(msec_o), 64'h3);

        // back-to-back write then read of an unlocked OFF entry
        @(negedge clk);
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B3; csr_wdata = 32'h0000AAAA;
        priv = PRIV_LVL_M;
        @(posedge clk);
        #1;
        check("b2b wr rvalid", 64'(rvalid), 64'(1));
        check("b2b wr err", 64'(err), 64'(0));
        csr_we = 1'b0;
        @(posedge clk);
        #1;
        check("b2b rd rvalid", 64'(rvalid), 64'(1));
        check("b2b rd rdata", 64'(rdata), 64'h0000AAA8);
        check("b2b addr3", 64'(addr_o[3]), 64'h2AAA8);
        csr_req = 1'b0;
        @(posedge clk);
        #1;
        check("idle rvalid", 64'(rvalid), 64'(0));

        // request dropped by a coincident reset
        @(negedge clk);
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = 12'h3A0; rst = 1'b1;
        @(posedge clk);
        #1;
        csr_req = 1'b0;
        check("rst rvalid", 64'(rvalid), 64'(0));
        check("rst rdata", 64'(rdata), 64'(0));
        check("rst cfg1", 64'(cfg_o[1]), 64'(0));
        check("rst addr3", 64'(addr_o[3]), 64'(0));
        check("rst mseccfg", 64'(msec_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 12'h747, 32'h0, PRIV_LVL_M, 0, 1, 32'h0, "post-rst msec");
        do_req(0, 12'h3A0, 32'h0, PRIV_LVL_M, 0, 1, 32'h0, "post-rst cfg");

        // rule-locking bypass
        do_req(1, 12'h747, 32'h4, PRIV_LVL_M, 0, 0, 32'h0, "rlb set");
        do_req(0, 12'h747, 32'h0, PRIV_LVL_M, 0, 1, 32'h4, "rlb rd");
        do_req(1, 12'h3A0, 32'h80, PRIV_LVL_M, 0, 0, 32'h0, "rlb lock0");
        do_req(1, 12'h3A0, 32'h03, PRIV_LVL_M, 0, 0, 32'h0, "rlb ovr");
        do_req(0, 12'h3A0, 32'h0, PRIV_LVL_M, 0, 1, 32'h03, "rlb ovr rd");
        do_req(1, 12'h3A0, 32'h80, PRIV_LVL_M, 0, 0, 32'h0, "relock0");
        do_req(1, 12'h747, 32'h0, PRIV_LVL_M, 0, 0, 32'h0, "rlb clr");
        do_req(1, 12'h747, 32'h4, PRIV_LVL_M, 0, 0, 32'h0, "rlb reset try");
        do_req(0, 12'h747, 32'h0, PRIV_LVL_M, 0, 1, 32'h0, "rlb blocked rd");
        do_req(1, 12'h3A0, 32'h03, PRIV_LVL_M, 0, 0, 32'h0, "locked wr");
        do_req(0, 12'h3A0, 32'h0, PRIV_LVL_M, 0, 1, 32'h80, "locked rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
